// File: rtl/pwm_pkg.sv
// Shared widths, configuration payload and FSM encoding for the PWM
// configuration path.
package pwm_pkg;

   localparam int PWM_CH_W  = 8;
   localparam int PWM_CNT_W = 28;

   typedef struct packed {
      logic                 en;
      logic [PWM_CH_W-1:0]  channel;
      logic [PWM_CNT_W-1:0] period;
      logic [PWM_CNT_W-1:0] hlevel;
   } pwm_cfg_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_GAP   = 2'd2
   } pwm_state_t;

endpackage

// File: rtl/pwm_rr_arbiter.sv
// Combinational round-robin picker: grants the first asserted request at or
// after ptr, wrapping modulo NUM_REQ.
module pwm_rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx
);

   int               pos;
   logic [IDX_W-1:0] cand;
   logic             found;

   // NOTE: blocking assignments with every output defaulted first keep this block latch-free.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      pos     = 0;
      cand    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = int'(ptr) + k;
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         cand = IDX_W'(pos);
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/pwm_cfg_arbiter.sv
// Shares the single PWM configuration bus between NUM_REQ requesters:
// round-robin accept, one-cycle broadcast, enforced idle gap, range check.
module pwm_cfg_arbiter
   import pwm_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int NUM_CHANNEL = 8,
   parameter int GAP_CYCLES  = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_vld,
   output logic [NUM_REQ-1:0]           req_rdy,
   input  logic [PWM_CH_W*NUM_REQ-1:0]  req_channel,
   input  logic [NUM_REQ-1:0]           req_en,
   input  logic [PWM_CNT_W*NUM_REQ-1:0] req_period,
   input  logic [PWM_CNT_W*NUM_REQ-1:0] req_hlevel,
   output logic                         pwm_config_vld,
   output logic [PWM_CH_W-1:0]          pwm_config_channel,
   output logic                         pwm_en,
   output logic [PWM_CNT_W-1:0]         pwm_period,
   output logic [PWM_CNT_W-1:0]         pwm_hlevel,
   output logic                         cfg_err,
   output logic                         busy
);

   localparam int                IDX_W    = $clog2(NUM_REQ);
   localparam logic [PWM_CH_W:0] CH_LIMIT = (PWM_CH_W+1)'(NUM_CHANNEL);
   localparam logic [7:0]        GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

   pwm_state_t       state_q;
   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] gnt_idx;
   logic [NUM_REQ-1:0] gnt;
   logic [7:0]       gap_cnt_q;
   pwm_cfg_t         cfg_q;
   pwm_cfg_t         req_cfg [NUM_REQ];
   logic             is_idle;
   logic             accept;
   logic             ch_ok;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign req_cfg[i] = '{en:      req_en[i],
                            channel: req_channel[PWM_CH_W*i +: PWM_CH_W],
                            period:  req_period[PWM_CNT_W*i +: PWM_CNT_W],
                            hlevel:  req_hlevel[PWM_CNT_W*i +: PWM_CNT_W]};
   end

   pwm_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req     (req_vld),
      .ptr     (ptr_q),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // Grants are offered only in IDLE; gating with rst keeps every output at 0 during reset.
   assign is_idle = (state_q == ST_IDLE) && !rst;
   assign req_rdy = is_idle ? gnt : '0;
   assign accept  = |(req_vld & req_rdy);

   // The 9-bit compare lets NUM_CHANNEL = 256 accept every 8-bit index.
   assign ch_ok          = {1'b0, cfg_q.channel} < CH_LIMIT;
   assign pwm_config_vld = (state_q == ST_ISSUE) && ch_ok;
   assign cfg_err        = (state_q == ST_ISSUE) && !ch_ok;
   assign busy           = (state_q != ST_IDLE);

   assign pwm_config_channel = cfg_q.channel;
   assign pwm_en             = cfg_q.en;
   assign pwm_period         = cfg_q.period;
   assign pwm_hlevel         = cfg_q.hlevel;

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= '0;
         gap_cnt_q <= '0;
         cfg_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  cfg_q   <= req_cfg[gnt_idx];
                  ptr_q   <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                  state_q <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (GAP_CYCLES > 0) begin
                  state_q   <= ST_GAP;
                  gap_cnt_q <= GAP_LOAD;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_GAP: begin
               if (gap_cnt_q == '0) state_q <= ST_IDLE;
               else                 gap_cnt_q <= gap_cnt_q - 1'b1;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
